// File: rtl/disp_queue.sv
// Clamping FIFO front end for the 7-segment driver; presents each queued value for at least
// HOLD_CYCLES and toggles disp_sel per new value. Saturation/ovf enabled by `define DISPQ_SAT_EN.
module disp_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel,
    input  logic                    we,
    input  logic                    clr,
    input  logic signed [15:0]      data_in,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    ovf,
    output logic [10:0]             disp_data,
    output logic                    disp_sel
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_CNT   = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [HW-1:0]   hold_q;
    logic [HW-1:0]   hold_d;

    logic [10:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_d;

    logic            flush_c;
    logic            push_c;
    logic            pop_c;
    logic [10:0]     cond_c;

    // A flush takes priority over any write presented in the same cycle
    assign flush_c = sel && clr;
    assign push_c  = sel && we && !full && !flush_c;

`ifdef DISPQ_SAT_EN
    localparam logic signed [15:0] SAT_MAX = 16'sd999;
    localparam logic signed [15:0] SAT_MIN = -16'sd999;

    logic clamp_c;

    always_comb begin
        cond_c  = data_in[10:0];
        clamp_c = 1'b0;
        if (data_in > SAT_MAX) begin
            cond_c  = 11'h3E7;
            clamp_c = 1'b1;
        end else if (data_in < SAT_MIN) begin
            cond_c  = 11'h419;
            clamp_c = 1'b1;
        end
    end

    // Sticky clamp indicator, cleared only by reset or flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (flush_c) begin
            ovf <= 1'b0;
        end else if (push_c && clamp_c) begin
            ovf <= 1'b1;
        end
    end
`else
    logic unused_c;

    assign cond_c   = data_in[10:0];
    assign ovf      = 1'b0;
    assign unused_c = ^data_in[15:11];
`endif

    // Presentation FSM: pop whenever the hold window has expired and data is waiting
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop_c   = 1'b1;
                    hold_d  = HOLD_RELOAD;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else if (count != '0) begin
                    pop_c  = 1'b1;
                    hold_d = HOLD_RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
        if (flush_c) begin
            state_d = IDLE;
            hold_d  = '0;
            pop_c   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign count_d = count + CW'(push_c) - CW'(pop_c);

    // Pointers, occupancy and the presented value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            disp_data <= '0;
            disp_sel  <= 1'b0;
        end else if (flush_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr    <= rd_ptr + AW'(1);
                disp_data <= mem[rd_ptr];
                disp_sel  <= ~disp_sel;
            end
            count <= count_d;
            full  <= (count_d == DEPTH_CNT);
        end
    end

    // Storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= cond_c;
        end
    end

endmodule

// File: tb/tb_disp_queue.sv
// Directed self-checking bench for disp_queue (DEPTH=4, HOLD_CYCLES=4).
module tb_disp_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 4;
`ifdef DISPQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               sel;
    logic               we;
    logic               clr;
    logic signed [15:0] data_in;
    logic               full;
    logic [2:0]         count;
    logic               ovf;
    logic [10:0]        disp_data;
    logic               disp_sel;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_sel  = 1'b0;

    disp_queue #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .we        (we),
        .clr       (clr),
        .data_in   (data_in),
        .full      (full),
        .count     (count),
        .ovf       (ovf),
        .disp_data (disp_data),
        .disp_sel  (disp_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic w, input logic c, input logic signed [15:0] d);
        sel     = s;
        we      = w;
        clr     = c;
        data_in = d;
    endtask

    task automatic flush();
        drive(1'b1, 1'b0, 1'b1, 16'sd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'sd0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'sd0);
        repeat (2) step();
        n_checks++;
        if ({full, count, ovf, disp_data, disp_sel} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got full=%b count=%0d ovf=%b data=%h sel=%b, want all 0",
                     full, count, ovf, disp_data, disp_sel);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (count !== 3'd0 || disp_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got count=%0d sel=%b, want 0/0", count, disp_sel);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 1'b1, 1'b0, 16'sd123);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'sd0);
        n_checks++;
        if (count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_count_after_push: got %0d want 1", count);
        end
        step();
        exp_sel = ~exp_sel;
        n_checks++;
        if (disp_data !== 11'd123 || disp_sel !== exp_sel || count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_present: got data=%h sel=%b count=%0d want 07b/%b/0",
                     disp_data, disp_sel, count, exp_sel);
        end
        flush();
    endtask

    task automatic test_saturation();
        logic [10:0] e_hi;
        logic [10:0] e_lo;
        e_hi = SAT ? 11'h3E7 : 11'h388;
        e_lo = SAT ? 11'h419 : 11'h478;
        drive(1'b1, 1'b1, 1'b0, 16'sd5000);
        step();
        n_checks++;
        if (ovf !== SAT) begin
            n_fail++;
            $display("FAIL sat_ovf_on_push: got %b want %b", ovf, SAT);
        end
        drive(1'b1, 1'b1, 1'b0, -16'sd5000);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'sd0);
        exp_sel = ~exp_sel;
        n_checks++;
        if (disp_data !== e_hi || disp_sel !== exp_sel || count !== 3'd1) begin
            n_fail++;
            $display("FAIL sat_high: got data=%h sel=%b count=%0d want %h/%b/1",
                     disp_data, disp_sel, count, e_hi, exp_sel);
        end
        repeat (3) step();
        n_checks++;
        if (disp_data !== e_hi || disp_sel !== exp_sel) begin
            n_fail++;
            $display("FAIL sat_hold: got data=%h sel=%b want %h/%b", disp_data, disp_sel, e_hi, exp_sel);
        end
        step();
        exp_sel = ~exp_sel;
        n_checks++;
        if (disp_data !== e_lo || disp_sel !== exp_sel || ovf !== SAT) begin
            n_fail++;
            $display("FAIL sat_low: got data=%h sel=%b ovf=%b want %h/%b/%b",
                     disp_data, disp_sel, ovf, e_lo, exp_sel, SAT);
        end
        flush();
        n_checks++;
        if (ovf !== 1'b0 || disp_data !== e_lo || disp_sel !== exp_sel || count !== 3'd0) begin
            n_fail++;
            $display("FAIL sat_clr: got ovf=%b data=%h sel=%b count=%0d want 0/%h/%b/0",
                     ovf, disp_data, disp_sel, count, e_lo, exp_sel);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e_val;
        for (int k = 0; k < 25; k++) begin
            if (k <= 5) drive(1'b1, 1'b1, 1'b0, 16'(k + 1));
            else        drive(1'b0, 1'b0, 1'b0, 16'sd0);
            step();
            if (k == 1 || k == 5 || k == 9 || k == 13 || k == 17) exp_sel = ~exp_sel;
            e_val = (k < 5) ? 11'd1 : (k < 9) ? 11'd2 : (k < 13) ? 11'd3 : (k < 17) ? 11'd4 : 11'd5;
            if (k >= 1) begin
                n_checks++;
                if (disp_data !== e_val || disp_sel !== exp_sel) begin
                    n_fail++;
                    $display("FAIL b2b_present k=%0d: got data=%0d sel=%b want %0d/%b",
                             k, disp_data, disp_sel, e_val, exp_sel);
                end
            end
            if (k == 4) begin
                n_checks++;
                if (count !== 3'd4 || full !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_full: got count=%0d full=%b want 4/1", count, full);
                end
            end
            if (k == 5) begin
                n_checks++;
                if (count !== 3'd3 || full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_drop: got count=%0d full=%b want 3/0", count, full);
                end
            end
        end
        n_checks++;
        if (count !== 3'd0 || full !== 1'b0 || disp_data !== 11'd5) begin
            n_fail++;
            $display("FAIL b2b_drain: got count=%0d full=%b data=%0d want 0/0/5", count, full, disp_data);
        end
    endtask

    task automatic test_coincide();
        flush();
        drive(1'b1, 1'b1, 1'b0, 16'sd7);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'sd0);
        step();
        exp_sel = ~exp_sel;
        n_checks++;
        if (disp_data !== 11'd7 || disp_sel !== exp_sel) begin
            n_fail++;
            $display("FAIL coin_first: got data=%0d sel=%b want 7/%b", disp_data, disp_sel, exp_sel);
        end
        drive(1'b1, 1'b1, 1'b0, 16'sd8);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'sd0);
        repeat (2) step();
        drive(1'b1, 1'b1, 1'b0, 16'sd9);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'sd0);
        exp_sel = ~exp_sel;
        n_checks++;
        if (disp_data !== 11'd8 || disp_sel !== exp_sel || count !== 3'd1) begin
            n_fail++;
            $display("FAIL coin_pop_push: got data=%0d sel=%b count=%0d want 8/%b/1",
                     disp_data, disp_sel, count, exp_sel);
        end
        repeat (3) step();
        n_checks++;
        if (disp_data !== 11'd8) begin
            n_fail++;
            $display("FAIL coin_hold: got data=%0d want 8", disp_data);
        end
        step();
        exp_sel = ~exp_sel;
        n_checks++;
        if (disp_data !== 11'd9 || disp_sel !== exp_sel || count !== 3'd0) begin
            n_fail++;
            $display("FAIL coin_last: got data=%0d sel=%b count=%0d want 9/%b/0",
                     disp_data, disp_sel, count, exp_sel);
        end
    endtask

    task automatic test_async_reset();
        flush();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 16'(10 + k));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 16'sd0);
        n_checks++;
        if (count !== 3'd3 || disp_data !== 11'd10) begin
            n_fail++;
            $display("FAIL areset_setup: got count=%0d data=%0d want 3/10", count, disp_data);
        end
        #2;
        rst = 1'b0;
        #1;
        exp_sel = 1'b0;
        n_checks++;
        if ({full, count, ovf, disp_data, disp_sel} !== 17'h0) begin
            n_fail++;
            $display("FAIL areset_immediate: got full=%b count=%0d ovf=%b data=%h sel=%b want all 0",
                     full, count, ovf, disp_data, disp_sel);
        end
        step();
        rst = 1'b1;
        repeat (2) step();
        n_checks++;
        if (count !== 3'd0 || disp_data !== 11'd0 || disp_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_after: got count=%0d data=%h sel=%b want 0/0/0",
                     count, disp_data, disp_sel);
        end
    endtask

    task automatic test_boundary();
        int          vals [5];
        logic [10:0] exps [5];
        logic        ovfs [5];
        vals = '{999, -999, 1010, -1000, 1023};
        exps = '{11'h3E7, 11'h419, (SAT ? 11'h3E7 : 11'h3F2), (SAT ? 11'h419 : 11'h418),
                 (SAT ? 11'h3E7 : 11'h3FF)};
        ovfs = '{1'b0, 1'b0, SAT, SAT, SAT};
        for (int i = 0; i < 5; i++) begin
            flush();
            drive(1'b1, 1'b1, 1'b0, 16'(vals[i]));
            step();
            drive(1'b0, 1'b0, 1'b0, 16'sd0);
            step();
            exp_sel = ~exp_sel;
            n_checks++;
            if (disp_data !== exps[i] || ovf !== ovfs[i] || disp_sel !== exp_sel) begin
                n_fail++;
                $display("FAIL boundary %0d: got data=%h ovf=%b sel=%b want %h/%b/%b",
                         vals[i], disp_data, ovf, disp_sel, exps[i], ovfs[i], exp_sel);
            end
        end
        flush();
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'sd0);
        test_reset();
        test_single();
        test_saturation();
        test_back_to_back();
        test_coincide();
        test_async_reset();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
